muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
Multi-cycle sequencer for the MIPS mult/div/mfhi/mflo ALU control codes; owns the HI/LO registers.
- Runs an iterative shift-add multiply or restoring divide over WIDTH cycles.
- Stalls the single-cycle datapath while busy.
- Sits beside the ALU and consumes the same 5-bit AluCtrl code.

Parameters:
WIDTH, 32, operand/HI/LO width (even, >=4)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  instruction in decode carries a valid AluCtrl this cycle
alu_ctrl  in  5  AluCtrl code: 01001 mult, 01110 div, 01010 mfhi, 10011 mflo; others ignored
signed_op  in  1  1 = mult/div, 0 = multu/divu
src_a  in  WIDTH  rs operand (multiplicand / dividend)
src_b  in  WIDTH  rt operand (multiplier / divisor)
stall  out  1  hold PC and pipeline this cycle
busy  out  1  iteration in progress
done  out  1  one-cycle pulse; HI/LO written at end of this cycle
rd_data  out  WIDTH  HI (mfhi) or LO (mflo); 0 otherwise
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
div_by_zero  out  1  last div had divisor 0; sticky until next accepted mult/div

Behaviour:
- Reset (async): state IDLE; hi, lo, counter, working registers = 0; busy, done, div_by_zero = 0.
- Outputs are 0 while reset is asserted.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE accepts when start=1 and alu_ctrl is mult or div.
  - Latches |src_a| and |src_b| (magnitudes when signed_op=1, raw values otherwise).
  - Latches result signs: product/quotient sign = a^b; remainder sign = a.
  - Clears div_by_zero. Counter = WIDTH. Next state MUL or DIV.
- MUL: each cycle, if acc LSB-multiplier bit = 1, add multiplicand to upper half. Then shift the 2*WIDTH accumulator right by 1 and decrement counter. At counter=1 go to FIX.
- DIV: restoring step each cycle.
  - Shift {rem, quo} left by 1 and trial-subtract the divisor.
  - If result >= 0, keep it and set quotient LSB = 1.
  - At counter=1 go to FIX.
- Divisor 0: IDLE goes straight to FIX. Result LO = all ones, HI = src_a unchanged; div_by_zero = 1.
- FIX (1 cycle): apply two's-complement negation per the latched signs.
- Signed overflow (-2^(W-1) / -1) needs no special case and yields LO = 0x80000000, HI = 0 for W=32.
- DONE (1 cycle): done=1; hi/lo written on the clock edge leaving DONE; next state IDLE.
- Latency: accept edge to hi/lo valid = WIDTH+2 cycles. Divide-by-zero takes 2 cycles.
- busy = 1 in MUL, DIV, FIX, DONE.
- stall = busy & start, for any code in the 4-code set. Covers back-to-back mult/div and mfhi/mflo-after-mult hazards.
  - Stalled instruction is re-presented and accepted/read the cycle after DONE.
- mfhi/mflo with busy = 0: rd_data combinationally = hi/lo, no stall.
- start with an unlisted code: ignored, no stall.
- Reset mid-operation aborts the operation; hi/lo return to 0; no done pulse.

Optional Feature:
Macro MULDIV_EARLY_EXIT_EN.
- Defined: in MUL, when remaining unsigned multiplier bits are all 0, the remaining shifts are applied in one cycle and the block goes to FIX.
  - Minimum MUL latency: 1 iteration.
  - Division is unchanged.
- Undefined: MUL always takes WIDTH iterations; latency is fixed.

Decomposition:
Package muldiv_pkg holds:
- AluCtrl code constants ALU_MULT, ALU_DIV, ALU_MFHI, ALU_MFLO (shared with ALU control).
- State enum muldiv_state_t.
- Counter width localparam, $clog2(WIDTH+1).

One sub-module, muldiv_step: combinational single-iteration add/shift and subtract/shift. muldiv_ctrl keeps FSM, counter, sign fixup, HI/LO and stall.

Test Plan:
- mult 7 * -3, signed_op=1 -> done at cycle 34 after accept; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- multu 0xFFFFFFFF * 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- div -17 / 5 signed -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFE (-2).
- div 0x80000000 / 0xFFFFFFFF signed -> LO=0x80000000, HI=0.
- div 100 / 0 -> done 2 cycles after accept; LO=0xFFFFFFFF, HI=100, div_by_zero=1.
- mfhi issued 5 cycles after a mult accept -> stall=1 until DONE; cycle after DONE rd_data = new HI. Reset pulsed mid-DIV -> hi=lo=0, busy=0, no done.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the mult/div sequencer: AluCtrl codes, FSM states and a
// helper that sizes the iteration counter.
package muldiv_pkg;

    localparam logic [4:0] ALU_MULT = 5'b01001;
    localparam logic [4:0] ALU_DIV  = 5'b01110;
    localparam logic [4:0] ALU_MFHI = 5'b01010;
    localparam logic [4:0] ALU_MFLO = 5'b10011;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_t;

    // Counter must hold WIDTH itself, hence WIDTH+1 distinct values.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer: shift-add multiply step and restoring divide step
// over the 2*WIDTH accumulator {upper, lower}.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] mul_next,
    output logic [2*WIDTH-1:0] div_next
);

    logic [WIDTH:0] add_sum_s;
    logic [WIDTH:0] shift_rem_s;
    logic [WIDTH:0] trial_s;

    // Multiply: conditional add into the upper half (carry kept), then shift right.
    always_comb begin
        add_sum_s = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0]) begin
            add_sum_s = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        end else begin
            add_sum_s = {1'b0, acc[2*WIDTH-1:WIDTH]};
        end
        mul_next = {add_sum_s, acc[WIDTH-1:1]};
    end

    // Divide: shifted remainder needs one extra bit before the trial subtract.
    always_comb begin
        shift_rem_s = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        trial_s     = shift_rem_s - {1'b0, operand};
        if (shift_rem_s >= {1'b0, operand}) begin
            div_next = {trial_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {shift_rem_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle mult/div/mfhi/mflo sequencer owning HI/LO; stalls the datapath while busy.
// Optional MULDIV_EARLY_EXIT_EN: MUL finishes once the remaining multiplier bits are zero.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       alu_ctrl,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    muldiv_state_t      state_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   operand_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               op_div_r, neg_q_r, neg_r_r;
    logic               busy_r, done_r, dz_r;
    logic [WIDTH-1:0]   hi_r, lo_r;

    logic               is_mult_s, is_div_s, is_mfhi_s, is_mflo_s;
    logic               sign_a_s, sign_b_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s, rd_data_s;
    logic [2*WIDTH-1:0] mul_next_s, div_next_s, fix_s;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_r),
        .operand  (operand_r),
        .mul_next (mul_next_s),
        .div_next (div_next_s)
    );

    // Decode the AluCtrl code and form operand magnitudes.
    always_comb begin
        is_mult_s = (alu_ctrl == ALU_MULT);
        is_div_s  = (alu_ctrl == ALU_DIV);
        is_mfhi_s = (alu_ctrl == ALU_MFHI);
        is_mflo_s = (alu_ctrl == ALU_MFLO);
        sign_a_s  = signed_op & src_a[WIDTH-1];
        sign_b_s  = signed_op & src_b[WIDTH-1];
        if (sign_a_s) mag_a_s = {WIDTH{1'b0}} - src_a;
        else          mag_a_s = src_a;
        if (sign_b_s) mag_b_s = {WIDTH{1'b0}} - src_b;
        else          mag_b_s = src_b;
    end

    // Sign fixup: full-width negate for products, per-half for quotient/remainder.
    always_comb begin
        fix_s = acc_r;
        if (op_div_r) begin
            if (neg_r_r) fix_s[2*WIDTH-1:WIDTH] = {WIDTH{1'b0}} - acc_r[2*WIDTH-1:WIDTH];
            else         fix_s[2*WIDTH-1:WIDTH] = acc_r[2*WIDTH-1:WIDTH];
            if (neg_q_r) fix_s[WIDTH-1:0] = {WIDTH{1'b0}} - acc_r[WIDTH-1:0];
            else         fix_s[WIDTH-1:0] = acc_r[WIDTH-1:0];
        end else if (neg_q_r) begin
            fix_s = {(2*WIDTH){1'b0}} - acc_r;
        end else begin
            fix_s = acc_r;
        end
    end

`ifdef MULDIV_EARLY_EXIT_EN
    logic [WIDTH-1:0] remain_mask_s;
    logic             mul_zero_s;

    // Unconsumed multiplier bits sit in the low cnt_r bits of the accumulator.
    always_comb begin
        remain_mask_s = ~({WIDTH{1'b1}} << cnt_r);
        mul_zero_s    = ((acc_r[WIDTH-1:0] & remain_mask_s) == {WIDTH{1'b0}});
    end
`endif

    // HI/LO read port for mfhi/mflo when the sequencer is idle.
    always_comb begin
        rd_data_s = {WIDTH{1'b0}};
        if (start && !busy_r && is_mfhi_s) begin
            rd_data_s = hi_r;
        end else if (start && !busy_r && is_mflo_s) begin
            rd_data_s = lo_r;
        end else begin
            rd_data_s = {WIDTH{1'b0}};
        end
    end

    // Sequencer FSM, counter, working registers and HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            acc_r     <= {(2*WIDTH){1'b0}};
            operand_r <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            op_div_r  <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dz_r      <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && (is_mult_s || is_div_s)) begin
                        busy_r   <= 1'b1;
                        dz_r     <= 1'b0;
                        op_div_r <= is_div_s;
                        cnt_r    <= CNT_FULL;
                        if (is_mult_s) begin
                            acc_r     <= {{WIDTH{1'b0}}, mag_b_s};
                            operand_r <= mag_a_s;
                            neg_q_r   <= sign_a_s ^ sign_b_s;
                            neg_r_r   <= 1'b0;
                            state_r   <= ST_MUL;
                        end else if (src_b == {WIDTH{1'b0}}) begin
                            // Divide by zero: HI keeps the raw dividend, LO all ones.
                            acc_r     <= {src_a, {WIDTH{1'b1}}};
                            operand_r <= {WIDTH{1'b0}};
                            neg_q_r   <= 1'b0;
                            neg_r_r   <= 1'b0;
                            dz_r      <= 1'b1;
                            state_r   <= ST_FIX;
                        end else begin
                            acc_r     <= {{WIDTH{1'b0}}, mag_a_s};
                            operand_r <= mag_b_s;
                            neg_q_r   <= sign_a_s ^ sign_b_s;
                            neg_r_r   <= sign_a_s;
                            state_r   <= ST_DIV;
                        end
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_MUL: begin
`ifdef MULDIV_EARLY_EXIT_EN
                    if (mul_zero_s) begin
                        acc_r   <= acc_r >> cnt_r;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_FIX;
                    end else begin
                        acc_r   <= mul_next_s;
                        cnt_r   <= cnt_r - CNT_ONE;
                        state_r <= (cnt_r == CNT_ONE) ? ST_FIX : ST_MUL;
                    end
`else
                    acc_r   <= mul_next_s;
                    cnt_r   <= cnt_r - CNT_ONE;
                    state_r <= (cnt_r == CNT_ONE) ? ST_FIX : ST_MUL;
`endif
                end
                ST_DIV: begin
                    acc_r   <= div_next_s;
                    cnt_r   <= cnt_r - CNT_ONE;
                    state_r <= (cnt_r == CNT_ONE) ? ST_FIX : ST_DIV;
                end
                ST_FIX: begin
                    acc_r   <= fix_s;
                    done_r  <= 1'b1;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    hi_r    <= acc_r[2*WIDTH-1:WIDTH];
                    lo_r    <= acc_r[WIDTH-1:0];
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall       = busy_r & start & (is_mult_s | is_div_s | is_mfhi_s | is_mflo_s);
    assign busy        = busy_r;
    assign done        = done_r;
    assign rd_data     = rd_data_s;
    assign hi          = hi_r;
    assign lo          = lo_r;
    assign div_by_zero = dz_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed mult/div vectors, stall/read hazards
// and reset abort.
module tb_muldiv_ctrl;

    localparam logic [4:0] C_MULT = 5'b01001;
    localparam logic [4:0] C_DIV  = 5'b01110;
    localparam logic [4:0] C_MFHI = 5'b01010;
    localparam logic [4:0] C_MFLO = 5'b10011;

    logic        clk = 1'b0;
    logic        reset, start, signed_op;
    logic [4:0]  alu_ctrl;
    logic [31:0] src_a, src_b, rd_data, hi, lo;
    logic        stall, busy, done, div_by_zero;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .alu_ctrl    (alu_ctrl),
        .signed_op   (signed_op),
        .src_a       (src_a),
        .src_b       (src_b),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .rd_data     (rd_data),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue(input logic [4:0] code, input logic sop, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz, input int elat);
        exp_t e;
        @(negedge clk);
        start = 1'b1; alu_ctrl = code; signed_op = sop; src_a = a; src_b = b;
        e.hi = ehi; e.lo = elo; e.dz = edz; e.lat = elat; e.acc_cyc = cyc + 1;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0; alu_ctrl = 5'b00000;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL timeout: %0d results still outstanding", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    // Monitor: pop expectation on done, check latency, then HI/LO after the write edge.
    initial begin
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op");
                end else begin
                    e   = sb_q.pop_front();
                    lat = cyc + 1 - e.acc_cyc;
                    chk("latency", 64'(lat), 64'(e.lat));
                    @(posedge clk); #1;
                    chk("hi", {32'h0, hi}, {32'h0, e.hi});
                    chk("lo", {32'h0, lo}, {32'h0, e.lo});
                    chk("div_by_zero", {63'h0, div_by_zero}, {63'h0, e.dz});
                end
            end
        end
    end

    initial begin
        int n;
        int dn;
        reset = 1'b1; start = 1'b0; alu_ctrl = 5'b00000; signed_op = 1'b0;
        src_a = 32'h0; src_b = 32'h0;
        repeat (3) @(negedge clk);
        start = 1'b1; alu_ctrl = C_MULT; #1;
        chk("rst_hi", {32'h0, hi}, 64'h0);
        chk("rst_lo", {32'h0, lo}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_dz", {63'h0, div_by_zero}, 64'h0);
        chk("rst_stall", {63'h0, stall}, 64'h0);
        start = 1'b0; alu_ctrl = 5'b00000;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);

        // Unlisted code is ignored.
        start = 1'b1; alu_ctrl = 5'b00000; #1;
        chk("unlisted_stall", {63'h0, stall}, 64'h0);
        chk("unlisted_rd", {32'h0, rd_data}, 64'h0);
        @(negedge clk);
        chk("unlisted_busy", {63'h0, busy}, 64'h0);
        start = 1'b0;

        issue(C_MULT, 1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34);
        wait_idle();
        issue(C_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34);
        wait_idle();
        issue(C_DIV, 1'b1, 32'hFFFF_FFEF, 32'h0000_0005, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 34);
        wait_idle();

        // Idle reads return HI/LO without stalling.
        start = 1'b1; alu_ctrl = C_MFHI; #1;
        chk("mfhi_idle", {32'h0, rd_data}, 64'h0000_0000_FFFF_FFFE);
        chk("mfhi_stall", {63'h0, stall}, 64'h0);
        alu_ctrl = C_MFLO; #1;
        chk("mflo_idle", {32'h0, rd_data}, 64'h0000_0000_FFFF_FFFD);
        @(negedge clk); start = 1'b0;

        issue(C_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34);
        wait_idle();
        issue(C_DIV, 1'b0, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 2);
        wait_idle();
        issue(C_DIV, 1'b0, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, 34);
        wait_idle();
        issue(C_MULT, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0014, 1'b0, 34);
        wait_idle();
        issue(C_DIV, 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, 34);
        wait_idle();
        issue(C_DIV, 1'b1, 32'h0000_0011, 32'hFFFF_FFFB, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 34);
        wait_idle();

        // mfhi hazard behind a multu: stalls until DONE, then reads new HI.
        issue(C_MULT, 1'b0, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 32'h0000_0000, 1'b0, 34);
        repeat (2) @(negedge clk);
        start = 1'b1; alu_ctrl = 5'b00000; #1;
        chk("busy_unlisted_stall", {63'h0, stall}, 64'h0);
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; alu_ctrl = C_MFHI;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            #1;
            chk("hazard_stall", {63'h0, stall}, 64'h1);
            @(negedge clk);
            n++;
        end
        chk("hazard_cycles", 64'(n), 64'd29);
        #1;
        chk("hazard_release", {63'h0, stall}, 64'h0);
        chk("hazard_rd", {32'h0, rd_data}, 64'h0000_0000_0000_0002);
        @(negedge clk); start = 1'b0; alu_ctrl = 5'b00000;
        wait_idle();

        // Reset mid-DIV aborts with no done pulse.
        @(negedge clk);
        start = 1'b1; alu_ctrl = C_DIV; signed_op = 1'b0; src_a = 32'h0000_0064; src_b = 32'h0000_0007;
        @(negedge clk); start = 1'b0; alu_ctrl = 5'b00000;
        repeat (8) @(negedge clk);
        reset = 1'b1; #1;
        chk("abort_hi", {32'h0, hi}, 64'h0);
        chk("abort_lo", {32'h0, lo}, 64'h0);
        chk("abort_busy", {63'h0, busy}, 64'h0);
        chk("abort_done", {63'h0, done}, 64'h0);
        @(negedge clk); reset = 1'b0;
        dn = 0;
        repeat (50) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        chk("abort_no_done", 64'(dn), 64'd0);

        issue(C_MULT, 1'b0, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A, 1'b0, 34);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
